// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage:
// instruction classes, opcodes, FSM states and the IF entry bundle.
package if_fetch_unit_pkg;

    typedef enum logic [3:0] {
        INST_TYPE_NONE   = 4'd0,
        INST_TYPE_R      = 4'd1,
        INST_TYPE_IALU   = 4'd2,
        INST_TYPE_LOAD   = 4'd3,
        INST_TYPE_STORE  = 4'd4,
        INST_TYPE_BRANCH = 4'd5,
        INST_TYPE_JUMP   = 4'd6
    } inst_type_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_DRAIN,
        ST_HOLD
    } fetch_state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc4;
        inst_type_e  itype;
        logic [3:0]  num;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// IF stage bus: instruction-memory req/ack channel plus
// the IF->ID bundle and ID's stall/redirect controls.
interface if_fetch_unit_if;

    logic        id_stall;
    logic        id_redirect;
    logic [31:0] nid_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] if_inst;
    logic [31:0] if_pc4;
    logic        if_valid;
    logic [3:0]  IF_ins_type;
    logic [3:0]  IF_ins_number;

    modport master (
        input  id_stall, id_redirect, nid_pc,
        input  imem_ack, imem_rdata,
        output imem_req, imem_addr,
        output if_inst, if_pc4, if_valid,
        output IF_ins_type, IF_ins_number
    );

    modport slave (
        output id_stall, id_redirect, nid_pc,
        output imem_ack, imem_rdata,
        input  imem_req, imem_addr,
        input  if_inst, if_pc4, if_valid,
        input  IF_ins_type, IF_ins_number
    );

endinterface

// File: rtl/if_fetch_unit_inst_classifier.sv
// Combinational opcode -> instruction-class decoder.
// An all-zero word is a bubble and classifies as NONE.
module inst_classifier
    import if_fetch_unit_pkg::*;
(
    input  logic [31:0] inst,
    output inst_type_e  itype
);

    logic [5:0] op;
    logic       nz;

    assign op = inst[31:26];
    assign nz = (inst != 32'h0);

    // Map the major opcode to its class
    always_comb begin
        itype = INST_TYPE_NONE;
        unique case (1'b1)
            !nz:                    itype = INST_TYPE_NONE;
            nz && op == OP_RTYPE:   itype = INST_TYPE_R;
            nz && op == OP_LW:      itype = INST_TYPE_LOAD;
            nz && op == OP_SW:      itype = INST_TYPE_STORE;
            nz && (op == OP_BEQ ||
                   op == OP_BNE):   itype = INST_TYPE_BRANCH;
            nz && op == OP_J:       itype = INST_TYPE_JUMP;
            default:                itype = INST_TYPE_IALU;
        endcase
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over req/ack,
// buffers one entry plus one skid, obeys ID stall and redirect.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd1
) (
    input logic            clk,
    input logic            rst,
    if_fetch_unit_if.master bus
);

    fetch_state_e state;
    logic [31:0]  pc;
    logic [31:0]  addr_q;
    logic         req_q;
    logic [3:0]   seq;
    fetch_entry_t buf_q;
    fetch_entry_t skid_q;
    fetch_entry_t new_e;
    fetch_entry_t buf_clr;
    inst_type_e   new_type;
    logic         ack_v;
    logic         consume;

    inst_classifier u_cls (
        .inst  (bus.imem_rdata),
        .itype (new_type)
    );

    // Ack only counts while our request is actually on the bus
    assign ack_v   = bus.imem_ack & req_q;
    assign consume = buf_q.valid & ~bus.id_stall & ~bus.id_redirect;

    // Incoming entry and the emptied-buffer value (pc4/num hold)
    always_comb begin
        new_e       = '0;
        new_e.valid = 1'b1;
        new_e.inst  = bus.imem_rdata;
        new_e.pc4   = addr_q + PC_STEP;
        new_e.itype = new_type;
        new_e.num   = seq;
        buf_clr       = buf_q;
        buf_clr.valid = 1'b0;
        buf_clr.inst  = 32'h0;
        buf_clr.itype = INST_TYPE_NONE;
    end

    // Fetch FSM, PC, output buffer and skid entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_FETCH;
            pc     <= RESET_PC;
            addr_q <= RESET_PC;
            req_q  <= 1'b0;
            seq    <= 4'd0;
            buf_q  <= '0;
            skid_q <= '0;
        end else if (bus.id_redirect) begin
            buf_q  <= buf_clr;
            skid_q <= '0;
            pc     <= bus.nid_pc;
            case (state)
                ST_FETCH: begin
                    if (req_q && !ack_v) begin
                        state <= ST_DRAIN;
                    end else begin
                        addr_q <= bus.nid_pc;
                        req_q  <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (ack_v) begin
                        state  <= ST_FETCH;
                        addr_q <= bus.nid_pc;
                    end
                end
                default: begin
                    state  <= ST_FETCH;
                    addr_q <= bus.nid_pc;
                    req_q  <= 1'b1;
                end
            endcase
        end else begin
            case (state)
                ST_FETCH: begin
                    req_q <= 1'b1;
                    if (ack_v) begin
                        pc     <= pc + PC_STEP;
                        addr_q <= pc + PC_STEP;
                        seq    <= seq + 4'd1;
                        if (!buf_q.valid || consume) begin
                            buf_q <= new_e;
                        end else begin
                            skid_q <= new_e;
                            state  <= ST_HOLD;
                            req_q  <= 1'b0;
                        end
                    end else if (consume) begin
                        buf_q <= buf_clr;
                    end
                end
                ST_HOLD: begin
                    if (consume) begin
                        buf_q  <= skid_q;
                        skid_q <= '0;
                        state  <= ST_FETCH;
                        req_q  <= 1'b1;
                        addr_q <= pc;
                    end
                end
                default: begin
                    if (ack_v) begin
                        state  <= ST_FETCH;
                        addr_q <= pc;
                    end
                end
            endcase
        end
    end

    assign bus.imem_req      = req_q;
    assign bus.imem_addr     = addr_q;
    assign bus.if_inst       = buf_q.inst;
    assign bus.if_pc4        = buf_q.pc4;
    assign bus.if_valid      = buf_q.valid;
    assign bus.IF_ins_type   = buf_q.itype;
    assign bus.IF_ins_number = buf_q.num;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus
// random stall/redirect/latency against a queue-based reference.
module tb_if_fetch_unit;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] word;
        logic [3:0]  num;
    } ent_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    if_fetch_unit_if bus ();

    if_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (32'd1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ent_t        q[$];
    int          mode;
    int          lat;
    int          maxlat;
    int          waited;
    logic        taint;
    logic        pend;
    logic [31:0] pend_addr;
    logic [31:0] next_fetch;
    logic [31:0] last_pc4;
    int          wcount;
    int          consumed;

    function automatic logic [5:0] opc(input logic [2:0] s);
        case (s)
            3'd0: return 6'h00;
            3'd1: return 6'h23;
            3'd2: return 6'h2B;
            3'd3: return 6'h04;
            3'd4: return 6'h05;
            3'd5: return 6'h02;
            3'd6: return 6'h08;
            default: return 6'h0D;
        endcase
    endfunction

    function automatic logic [31:0] word(input logic [31:0] a);
        if (mode == 0) return a + 32'h100;
        return {opc(a[2:0]), a[25:0]};
    endfunction

    function automatic logic [3:0] mtype(input logic [31:0] w);
        if (w == 32'h0) return 4'd0;
        case (w[31:26])
            6'h00:        return 4'd1;
            6'h23:        return 4'd3;
            6'h2B:        return 4'd4;
            6'h04, 6'h05: return 4'd5;
            6'h02:        return 4'd6;
            default:      return 4'd2;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        taint      = 1'b0;
        pend       = 1'b0;
        pend_addr  = 32'h0;
        next_fetch = 32'h0;
        last_pc4   = 32'h0;
        wcount     = 0;
        waited     = 0;
        lat        = 0;
        maxlat     = 0;
    endtask

    // Assert rst mid-cycle, check async clear, release at a negedge
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_req", {31'h0, bus.imem_req}, 32'h0);
        chk("rst_valid", {31'h0, bus.if_valid}, 32'h0);
        chk("rst_inst", bus.if_inst, 32'h0);
        chk("rst_pc4", bus.if_pc4, 32'h0);
        chk("rst_type", {28'h0, bus.IF_ins_type}, 32'h0);
        chk("rst_num", {28'h0, bus.IF_ins_number}, 32'h0);
        model_reset();
        bus.id_stall    = 1'b0;
        bus.id_redirect = 1'b0;
        bus.imem_ack    = 1'b1;
        bus.imem_rdata  = 32'hDEAD_BEEF;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_req", {31'h0, bus.imem_req}, 32'h0);
    endtask

    // One cycle: drive ID/imem at negedge, check and update the model
    task automatic step(input logic st, input logic rd,
                        input logic [31:0] nid);
        logic        ack;
        logic        req;
        logic        valid;
        logic [31:0] addr;
        @(negedge clk);
        req  = bus.imem_req;
        addr = bus.imem_addr;
        ack  = req && (waited >= lat);
        bus.id_stall    = st;
        bus.id_redirect = rd;
        bus.nid_pc      = nid;
        bus.imem_ack    = ack;
        bus.imem_rdata  = ack ? word(addr) : $urandom();
        #1;
        valid = bus.if_valid;
        chk("valid", {31'h0, valid}, {31'h0, q.size() > 0});
        if (q.size() > 0) begin
            chk("inst", bus.if_inst, q[0].word);
            chk("pc4", bus.if_pc4, q[0].addr + 32'd1);
            chk("type", {28'h0, bus.IF_ins_type},
                {28'h0, mtype(q[0].word)});
            chk("num", {28'h0, bus.IF_ins_number}, {28'h0, q[0].num});
            last_pc4 = q[0].addr + 32'd1;
        end else begin
            chk("idle_inst", bus.if_inst, 32'h0);
            chk("idle_type", {28'h0, bus.IF_ins_type}, 32'h0);
            chk("idle_pc4", bus.if_pc4, last_pc4);
        end
        chk("req", {31'h0, req}, {31'h0, q.size() < 2});
        if (req && pend) chk("addr_stable", addr, pend_addr);
        if (req && !taint) chk("fetch_addr", addr, next_fetch);
        if (valid && !st && !rd && q.size() > 0) begin
            void'(q.pop_front());
            consumed++;
        end
        if (rd) begin
            q.delete();
            next_fetch = nid;
        end
        if (req && ack && !rd && !taint) begin
            q.push_back('{addr: addr, word: word(addr),
                          num: 4'(wcount)});
            wcount++;
            next_fetch = addr + 32'd1;
        end
        if (req && ack) taint = 1'b0;
        if (rd && req && !ack) taint = 1'b1;
        pend      = req && !ack;
        pend_addr = addr;
        if (req && ack) begin
            waited = 0;
            lat    = $urandom_range(maxlat, 0);
        end else if (req) begin
            waited++;
        end else begin
            waited = 0;
        end
    endtask

    initial begin
        logic [31:0] nf;
        logic [3:0]  exp_n;
        logic [3:0]  t5 [5];
        int          c0;
        logic [31:0] nid;
        checks = 0;
        errors = 0;
        consumed = 0;
        mode = 0;
        rst = 1'b1;
        bus.id_stall    = 1'b0;
        bus.id_redirect = 1'b0;
        bus.nid_pc      = 32'h0;
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = 32'h0;
        do_reset();

        // Zero-wait stream, numbers wrap after 16
        step(1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b0, 32'h0);
            chk("t1_inst", bus.if_inst, 32'h100 + 32'(k));
            chk("t1_pc4", bus.if_pc4, 32'(k + 1));
            chk("t1_num", {28'h0, bus.IF_ins_number}, 32'(k % 16));
        end

        // Stall 3 cycles: skid fills, request drops
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        chk("t2_req_a", {31'h0, bus.imem_req}, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        chk("t2_req_b", {31'h0, bus.imem_req}, 32'h0);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 32'h0);

        // Latency 3, redirect in first wait cycle
        mode = 1;
        nf = next_fetch;
        lat = 3;
        step(1'b0, 1'b1, 32'h40);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 32'h0);
            chk("t3_hold", bus.imem_addr, nf);
        end
        step(1'b0, 1'b0, 32'h0);
        chk("t3_addr", bus.imem_addr, 32'h40);
        step(1'b0, 1'b0, 32'h0);
        chk("t3_inst", bus.if_inst, 32'h0000_0040);
        t5 = '{4'd3, 4'd4, 4'd5, 4'd5, 4'd6};
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0, 32'h0);
            chk("t5_type", {28'h0, bus.IF_ins_type}, {28'h0, t5[k]});
        end

        // Redirect together with stall while skid is full
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h40);
        exp_n = 4'(wcount);
        step(1'b0, 1'b0, 32'h0);
        chk("t4_empty", {31'h0, bus.if_valid}, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        chk("t4_inst", bus.if_inst, 32'h0000_0040);
        chk("t4_num", {28'h0, bus.IF_ins_number}, {28'h0, exp_n});

        // Reset while a dropped fetch is outstanding
        lat = 3;
        step(1'b0, 1'b1, 32'h80);
        step(1'b0, 1'b0, 32'h0);
        do_reset();
        step(1'b0, 1'b0, 32'h0);
        chk("t6_req", {31'h0, bus.imem_req}, 32'h1);
        chk("t6_addr", bus.imem_addr, 32'h0);

        // Random latency, stalls and redirects
        maxlat = 3;
        c0 = consumed;
        for (int k = 0; k < 1500; k++) begin
            nid = ($urandom_range(9, 0) == 0) ? 32'hFFFF_FFFE
                                              : 32'($urandom_range(1023, 0));
            step($urandom_range(3, 0) == 0,
                 $urandom_range(11, 0) == 0, nid);
        end
        chk("progress", {31'h0, (consumed - c0) > 100}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
